// File: rtl/switch_gate_pkg.sv
// switch_gate_pkg: gate mode encodings and the mode-selected reduction helper
package switch_gate_pkg;
  typedef enum logic [1:0] {
    MODE_AND  = 2'd0,
    MODE_OR   = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_NAND = 2'd3
  } mode_t;

  function automatic logic gate_sel(input mode_t mode, input logic all_and, input logic any_or, input logic parity);
    return mode == MODE_AND ? all_and :
           mode == MODE_OR  ? any_or  :
           mode == MODE_XOR ? parity  : ~all_and;
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-flop synchronizer plus stability counter for one switch
module debounce_filter #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  // accept the synced level only after it has differed from stable for DEBOUNCE_CYCLES clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/switch_gate_debounce.sv
// switch_gate_debounce: debounced switches feeding a mode-selected registered gate
module switch_gate_debounce
  import switch_gate_pkg::*;
#(
  parameter int NUM_SWITCHES    = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [NUM_SWITCHES-1:0] i_Switch,
  input  logic [1:0]              i_Mode,
  output logic [NUM_SWITCHES-1:0] o_Debounced,
  output logic                    o_LED_0,
  output logic                    o_Change
);
  logic gate;
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_ch
    debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filter (
      .clk   (i_Clk),
      .rst_n (i_Rst_L),
      .raw   (i_Switch[i]),
      .stable(o_Debounced[i])
    );
  end
  // gate is evaluated on the current debounced bits and the raw (undebounced) mode
  always_comb gate = gate_sel(mode_t'(i_Mode), &o_Debounced, |o_Debounced, ^o_Debounced);
  // register the gate result and flag the cycle in which it takes a new value
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LED_0  <= 1'b0;
      o_Change <= 1'b0;
    end else begin
      o_LED_0  <= gate;
      o_Change <= gate != o_LED_0;
    end
  end
endmodule

// File: tb/tb_switch_gate_debounce.sv
// tb_switch_gate_debounce: table-driven scoreboard bench for switch_gate_debounce
module tb_switch_gate_debounce;
  import switch_gate_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw, mode, deb;
  logic       led, chg;
  logic [3:0] sw4, deb4;
  logic [1:0] mode4;
  logic       led4, chg4;
  int         tests = 0;
  int         fails = 0;

  typedef struct {
    string      name;
    logic [1:0] deb;
    logic       led;
    logic       chg;
  } exp_t;

  typedef struct {
    string      name;
    logic [1:0] sw;
    logic [1:0] mode;
    int         ticks;
    logic [1:0] deb;
    logic       led;
    logic       chg;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  switch_gate_debounce #(.NUM_SWITCHES(2), .DEBOUNCE_CYCLES(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw), .i_Mode(mode),
    .o_Debounced(deb), .o_LED_0(led), .o_Change(chg)
  );

  switch_gate_debounce #(.NUM_SWITCHES(4), .DEBOUNCE_CYCLES(4)) dut4 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch(sw4), .i_Mode(mode4),
    .o_Debounced(deb4), .o_LED_0(led4), .o_Change(chg4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input string name, input logic [1:0] d, input logic l, input logic c);
    exp_t e;
    e.name = name;
    e.deb  = d;
    e.led  = l;
    e.chg  = c;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sbq.pop_front();
      check({e.name, ".deb"}, 32'(deb), 32'(e.deb));
      check({e.name, ".led"}, 32'(led), 32'(e.led));
      check({e.name, ".chg"}, 32'(chg), 32'(e.chg));
    end
  endtask

  initial begin
    vecs[0] = '{"idle00",     2'b00, MODE_AND,  2, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{"rise_t5",    2'b11, MODE_AND,  5, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{"rise_t6",    2'b11, MODE_AND,  1, 2'b11, 1'b0, 1'b0};
    vecs[3] = '{"rise_t7",    2'b11, MODE_AND,  1, 2'b11, 1'b1, 1'b1};
    vecs[4] = '{"rise_t8",    2'b11, MODE_AND,  1, 2'b11, 1'b1, 1'b0};
    vecs[5] = '{"settle01",   2'b01, MODE_AND,  8, 2'b01, 1'b0, 1'b0};
    vecs[6] = '{"mode_or",    2'b01, MODE_OR,   1, 2'b01, 1'b1, 1'b1};
    vecs[7] = '{"mode_xor",   2'b01, MODE_XOR,  1, 2'b01, 1'b1, 1'b0};
    vecs[8] = '{"mode_nand",  2'b01, MODE_NAND, 1, 2'b01, 1'b1, 1'b0};
    vecs[9] = '{"mode_and",   2'b01, MODE_AND,  1, 2'b01, 1'b0, 1'b1};

    rst_n = 1'b0;
    sw    = 2'b00;
    mode  = MODE_AND;
    sw4   = 4'b1011;
    mode4 = MODE_XOR;
    #12;
    push_exp("reset", 2'b00, 1'b0, 1'b0);
    pop_check();
    rst_n = 1'b1;

    repeat (6) tick();
    check("w4_led_t6", 32'(led4), 32'd0);
    tick();
    check("w4_led_t7", 32'(led4), 32'd1);
    check("w4_chg_t7", 32'(chg4), 32'd1);

    for (int i = 0; i < 10; i++) begin
      sw   = vecs[i].sw;
      mode = vecs[i].mode;
      push_exp(vecs[i].name, vecs[i].deb, vecs[i].led, vecs[i].chg);
      repeat (vecs[i].ticks) tick();
      pop_check();
    end

    sw = 2'b00;
    push_exp("settle00", 2'b00, 1'b0, 1'b0);
    repeat (8) tick();
    pop_check();

    sw = 2'b01;
    for (int t = 1; t <= 15; t++) begin
      push_exp($sformatf("glitch_t%0d", t), 2'b00, 1'b0, 1'b0);
      tick();
      if (t == 3) sw = 2'b00;
      pop_check();
    end

    mode = MODE_NAND;
    push_exp("nand00", 2'b00, 1'b1, 1'b1);
    tick();
    pop_check();

    sw = 2'b01;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    push_exp("async_rst", 2'b00, 1'b0, 1'b0);
    #1 pop_check();
    mode = MODE_AND;
    #2 rst_n = 1'b1;
    push_exp("restart_t5", 2'b00, 1'b0, 1'b0);
    repeat (5) tick();
    pop_check();
    push_exp("restart_t6", 2'b01, 1'b0, 1'b0);
    tick();
    pop_check();

    sw   = 2'b00;
    mode = MODE_NAND;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    push_exp("nand_rel_t1", 2'b00, 1'b1, 1'b1);
    tick();
    pop_check();
    push_exp("nand_rel_t2", 2'b00, 1'b1, 1'b0);
    tick();
    pop_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
